// File: rtl/freq_divider_prog.sv
// Multi-channel run-time programmable clock divider with per-channel ratio, enable and tick.
// Define FREQ_DIV_SYNC_EN to add the sync input that phase-aligns all enabled channels.
module freq_divider_prog #(
  parameter int unsigned CH          = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = 2
) (
  input  logic                clk_in,
  input  logic                nreset,
  input  logic [CH-1:0]       enable,
  input  logic [CH*CNT_W-1:0] div_val,
  input  logic [CH-1:0]       div_load,
  output logic [CH-1:0]       clk_out,
  output logic [CH-1:0]       tick,
  output logic [CH-1:0]       load_pending
`ifdef FREQ_DIV_SYNC_EN
  ,
  input  logic                sync
`endif
);

  localparam int unsigned MIN_DIV = 2;

  logic sync_c;

`ifdef FREQ_DIV_SYNC_EN
  assign sync_c = sync;
`else
  assign sync_c = 1'b0;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pval_q, pval_d;
    logic [CNT_W-1:0] val_clamped_c;
    logic [CNT_W-1:0] high_len_c;
    logic             pend_q, pend_d;
    logic             wrap_c;
    logic             clk_d;
    logic             clk_q, tick_q;

    // Next-state: park when disabled, wrap at terminal count (or on sync), else count up
    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      pval_d = pval_q;
      pend_d = pend_q;

      val_clamped_c = div_val[i*CNT_W +: CNT_W];
      if (val_clamped_c < CNT_W'(MIN_DIV)) val_clamped_c = CNT_W'(MIN_DIV);

      wrap_c = enable[i] & (sync_c | (cnt_q == act_q - CNT_W'(1)));

      if (!enable[i]) begin
        if (pend_q) begin
          act_d  = pval_q;
          pend_d = 1'b0;
        end
        cnt_d = act_d - CNT_W'(1);
      end else if (wrap_c) begin
        cnt_d = '0;
        if (pend_q) begin
          act_d  = pval_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      // A load landing on an applying edge is held for the following boundary
      if (div_load[i]) begin
        pval_d = val_clamped_c;
        pend_d = 1'b1;
      end

      // Ratio only changes when cnt_d is 0, so the current ratio gives the right threshold
      high_len_c = act_q - (act_q >> 1);
      clk_d      = enable[i] & (cnt_d < high_len_c);
    end

    always_ff @(posedge clk_in or negedge nreset) begin
      if (!nreset) begin
        cnt_q  <= CNT_W'(DIV_DEFAULT - 1);
        act_q  <= CNT_W'(DIV_DEFAULT);
        pval_q <= CNT_W'(DIV_DEFAULT);
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        pval_q <= pval_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= wrap_c;
      end
    end

    assign clk_out[i]      = clk_q;
    assign tick[i]         = tick_q;
    assign load_pending[i] = pend_q;
  end

endmodule

// File: tb/tb_freq_divider_prog.sv
// Directed self-checking bench for freq_divider_prog (CH=2, CNT_W=8, DIV_DEFAULT=2).
module tb_freq_divider_prog;

  localparam int unsigned CH    = 2;
  localparam int unsigned CNT_W = 8;

  logic                clk_in;
  logic                nreset;
  logic [CH-1:0]       enable;
  logic [CH*CNT_W-1:0] div_val;
  logic [CH-1:0]       div_load;
  logic [CH-1:0]       clk_out;
  logic [CH-1:0]       tick;
  logic [CH-1:0]       load_pending;
  logic                sync;

  int n_tests;
  int n_fail;

  freq_divider_prog #(
    .CH(CH),
    .CNT_W(CNT_W),
    .DIV_DEFAULT(2)
  ) dut (
    .clk_in(clk_in),
    .nreset(nreset),
    .enable(enable),
    .div_val(div_val),
    .div_load(div_load),
    .clk_out(clk_out),
    .tick(tick),
    .load_pending(load_pending)
`ifdef FREQ_DIV_SYNC_EN
    ,
    .sync(sync)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] exp_clk5;
    logic [5:0] exp_tick5;
    logic [5:0] exp_tick_sync0;
    logic [5:0] exp_tick_sync1;

    n_tests  = 0;
    n_fail   = 0;
    nreset   = 1'b0;
    enable   = '0;
    div_val  = '0;
    div_load = '0;
    sync     = 1'b0;

    // reset state
    #12;
    check("reset_clk_out", 32'(clk_out), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_load_pending", 32'(load_pending), 32'h0);
    @(negedge clk_in);
    nreset = 1'b1;
    step();

    // 1: ch0 at ratio 2, ch1 idle
    enable = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("t1_clk_%0d", k), 32'(clk_out), 32'((k % 2 == 1) ? 2'b01 : 2'b00));
      check($sformatf("t1_tick_%0d", k), 32'(tick), 32'((k % 2 == 1) ? 2'b01 : 2'b00));
    end

    // 2: load ratio 5 mid-period
    div_val[7:0] = 8'd5;
    div_load     = 2'b01;
    step();
    div_load = 2'b00;
    check("t2_pending", 32'(load_pending), 32'h1);
    check("t2_clk_before", 32'(clk_out[0]), 32'h0);
    exp_clk5  = 6'b100111;
    exp_tick5 = 6'b100001;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("t2_clk_%0d", k), 32'(clk_out[0]), 32'(exp_clk5[k]));
      check($sformatf("t2_tick_%0d", k), 32'(tick[0]), 32'(exp_tick5[k]));
      check($sformatf("t2_pend_%0d", k), 32'(load_pending[0]), 32'h0);
    end

    // 3: load 0 then 1, both clamp to 2
    div_val[7:0] = 8'd0;
    div_load     = 2'b01;
    step();
    div_val[7:0] = 8'd1;
    step();
    div_load = 2'b00;
    check("t3_pending", 32'(load_pending[0]), 32'h1);
    step();
    step();
    check("t3_pending_hold", 32'(load_pending[0]), 32'h1);
    step();
    check("t3_wrap_clk", 32'(clk_out[0]), 32'h1);
    check("t3_wrap_tick", 32'(tick[0]), 32'h1);
    check("t3_wrap_pend", 32'(load_pending[0]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t3_clk_%0d", k), 32'(clk_out[0]), 32'((k % 2 == 1) ? 1 : 0));
    end

    // 4: ch1 load 4 on its exact wrap edge
    enable = 2'b11;
    step();
    check("t4_en_tick", 32'(tick[1]), 32'h1);
    step();
    check("t4_clk_low", 32'(clk_out[1]), 32'h0);
    div_val[15:8] = 8'd4;
    div_load      = 2'b10;
    step();
    div_load = 2'b00;
    check("t4_wrap_tick", 32'(tick[1]), 32'h1);
    check("t4_wrap_pend", 32'(load_pending[1]), 32'h1);
    step();
    check("t4_old_clk", 32'(clk_out[1]), 32'h0);
    check("t4_old_pend", 32'(load_pending[1]), 32'h1);
    step();
    check("t4_apply_tick", 32'(tick[1]), 32'h1);
    check("t4_apply_pend", 32'(load_pending[1]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t4_clk_%0d", k), 32'(clk_out[1]), 32'((k == 0 || k == 3) ? 1 : 0));
      check($sformatf("t4_tick_%0d", k), 32'(tick[1]), 32'((k == 3) ? 1 : 0));
    end

    // 5: async reset mid-period at ratio 7, cnt=3, with a load pending
    div_val[7:0] = 8'd7;
    div_load     = 2'b01;
    step();
    div_load = 2'b00;
    step();
    check("t5_apply_tick", 32'(tick[0]), 32'h1);
    step();
    step();
    div_val[7:0] = 8'd9;
    div_load     = 2'b01;
    step();
    div_load = 2'b00;
    check("t5_mid_clk", 32'(clk_out[0]), 32'h1);
    check("t5_mid_pend", 32'(load_pending[0]), 32'h1);
    #2;
    nreset = 1'b0;
    #1;
    check("t5_rst_clk", 32'(clk_out), 32'h0);
    check("t5_rst_tick", 32'(tick), 32'h0);
    check("t5_rst_pend", 32'(load_pending), 32'h0);
    @(negedge clk_in);
    nreset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t5_clk_%0d", k), 32'(clk_out), 32'((k % 2 == 0) ? 2'b11 : 2'b00));
      check($sformatf("t5_tick_%0d", k), 32'(tick), 32'((k % 2 == 0) ? 2'b11 : 2'b00));
      check($sformatf("t5_pend_%0d", k), 32'(load_pending), 32'h0);
    end

    // disabled channel applies a pending ratio immediately and parks
    enable   = 2'b00;
    div_val  = {8'd6, 8'd3};
    div_load = 2'b11;
    step();
    div_load = 2'b00;
    check("dis_clk", 32'(clk_out), 32'h0);
    check("dis_pend_set", 32'(load_pending), 32'h3);
    step();
    check("dis_pend_applied", 32'(load_pending), 32'h0);
    enable = 2'b11;
    step();
    check("dis_en_tick", 32'(tick), 32'h3);
    step();
    step();
    check("dis_no_tick", 32'(tick), 32'h0);

`ifdef FREQ_DIV_SYNC_EN
    // 6: sync aligns ch0 (ratio 3) and ch1 (ratio 6)
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("t6_sync_tick", 32'(tick), 32'h3);
    check("t6_sync_clk", 32'(clk_out), 32'h3);
    exp_tick_sync0 = 6'b100100;
    exp_tick_sync1 = 6'b100000;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("t6_tick_%0d", k), 32'(tick),
            32'({exp_tick_sync1[k], exp_tick_sync0[k]}));
    end
`else
    // free-running ratios 3 and 6 after the common enable edge
    step();
    check("free_tick_a", 32'(tick), 32'h1);
    exp_tick_sync0 = 6'b100100;
    exp_tick_sync1 = 6'b000100;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("free_tick_%0d", k), 32'(tick),
            32'({exp_tick_sync1[k], exp_tick_sync0[k]}));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
